// File: rtl/dequantizer.sv
// Streaming signed int8 -> wide fixed-point dequantizer with a writable per-channel scale table.
// Latency: 2 cycles from accept to valid_out; throughput 1 beat/cycle.
// Backpressure: the whole pipe (bubbles included) freezes while valid_out && !ready_out; ready_in = !valid_out || ready_out.
module dequantizer #(
   parameter int IN_W         = 8,
   parameter int OUT_W        = 32,
   parameter int MULT_W       = 16,
   parameter int SHIFT        = 8,
   parameter int ZERO_POINT   = 0,
   parameter int NUM_CH       = 4,
   parameter int DEFAULT_MULT = 256,
   localparam int AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   output logic                     ready_in,
   input  logic signed [IN_W-1:0]   data_in,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic signed [OUT_W-1:0]  data_out,
   output logic                     last_out,
   input  logic                     ch_clear,
   input  logic                     cfg_we,
   input  logic [AW-1:0]            cfg_addr,
   input  logic signed [MULT_W-1:0] cfg_data
);

   // Widths: zero-point-adjusted sample, full product, and a working width wide
   // enough for the rounding add, the shift and a clean saturation compare.
   localparam int DW  = IN_W + 1;
   localparam int PW  = DW + MULT_W;
   localparam int EW0 = (PW + 2 > OUT_W + 1) ? PW + 2 : OUT_W + 1;
   localparam int EW  = (EW0 > SHIFT + 2) ? EW0 : SHIFT + 2;

   localparam logic [AW-1:0]            LAST_CH = AW'(NUM_CH - 1);
   localparam logic signed [MULT_W-1:0] DEF_M   = MULT_W'(DEFAULT_MULT);
   // Half an output LSB; evaluates to zero when SHIFT is 0, so no rounding then.
   localparam logic signed [EW-1:0]     RND     = (EW'(1) << SHIFT) >> 1;
   localparam logic signed [EW-1:0]     MAXV    = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [EW-1:0]     MINV    = {{(EW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [MULT_W-1:0] scale_tbl [NUM_CH];
   logic [AW-1:0]            ch_cnt;
   logic [AW-1:0]            ch_eff;
   logic signed [MULT_W-1:0] scale_sel;
   logic                     adv;
   logic                     accept;

   logic                     v1;
   logic                     l1;
   logic signed [DW-1:0]     d1;
   logic signed [DW-1:0]     d_next;
   logic signed [MULT_W-1:0] s1;

   logic signed [PW-1:0]     prod;
   logic signed [EW-1:0]     prod_ext;
   logic signed [EW-1:0]     sum;
   logic signed [EW-1:0]     shifted;
   logic signed [OUT_W-1:0]  sat;

   assign adv      = !valid_out || ready_out;
   assign ready_in = adv;
   assign accept   = valid_in && adv;
   // A clear redirects this cycle's lookup to channel 0 without waiting for the register.
   assign ch_eff   = ch_clear ? '0 : ch_cnt;
   assign d_next   = DW'(data_in) - DW'(ZERO_POINT);

   // Scale lookup for the current channel; the table register is read before any same-edge write lands.
   always_comb begin
      scale_sel = scale_tbl[0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_eff == AW'(i)) scale_sel = scale_tbl[i];
      end
   end

   // Scale table: reset to the default multiplier; out-of-range addresses match no entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) scale_tbl[i] <= DEF_M;
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == AW'(i)) scale_tbl[i] <= cfg_data;
         end
      end
   end

   // Channel counter: advances per accepted beat from the (possibly cleared) channel, wrapping at the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_cnt <= '0;
      end else if (accept) begin
         ch_cnt <= (ch_eff == LAST_CH) ? '0 : ch_eff + AW'(1);
      end else if (ch_clear) begin
         ch_cnt <= '0;
      end
   end

   // Stage 1: capture the zero-point-adjusted sample, its scale and its last-channel flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         l1 <= 1'b0;
         d1 <= '0;
         s1 <= '0;
      end else if (adv) begin
         v1 <= accept;
         l1 <= (ch_eff == LAST_CH);
         d1 <= d_next;
         s1 <= scale_sel;
      end
   end

   // Multiply, round half toward +inf, arithmetic shift, then clamp to the output range.
   always_comb begin
      prod     = PW'(d1) * PW'(s1);
      prod_ext = EW'(prod);
      sum      = prod_ext + RND;
      shifted  = sum >>> SHIFT;
      if (shifted > MAXV) begin
         sat = {1'b0, {(OUT_W - 1){1'b1}}};
      end else if (shifted < MINV) begin
         sat = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
         sat = shifted[OUT_W-1:0];
      end
   end

   // Stage 2: output register, held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         data_out  <= '0;
      end else if (adv) begin
         valid_out <= v1;
         last_out  <= l1;
         data_out  <= sat;
      end
   end

endmodule

// File: tb/tb_dequantizer.sv
// Bench for dequantizer: a default 4-channel instance driven by directed and random traffic,
// plus a narrow SHIFT=0 single-channel instance with a nonzero zero point for saturation.
module tb_dequantizer;
   localparam int NCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance signals
   logic               valid_in  = 1'b0;
   logic               ready_in;
   logic signed [7:0]  data_in   = '0;
   logic               valid_out;
   logic               ready_out = 1'b1;
   logic signed [31:0] data_out;
   logic               last_out;
   logic               ch_clear  = 1'b0;
   logic               cfg_we    = 1'b0;
   logic [1:0]         cfg_addr  = '0;
   logic signed [15:0] cfg_data  = '0;

   // Saturation instance signals
   logic               b_valid_in  = 1'b0;
   logic               b_ready_in;
   logic signed [7:0]  b_data_in   = '0;
   logic               b_valid_out;
   logic               b_ready_out = 1'b1;
   logic signed [15:0] b_data_out;
   logic               b_last_out;
   logic               b_ch_clear  = 1'b0;
   logic               b_cfg_we    = 1'b0;
   logic [0:0]         b_cfg_addr  = '0;
   logic signed [15:0] b_cfg_data  = '0;

   dequantizer u_dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .last_out(last_out),
      .ch_clear(ch_clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
   );

   dequantizer #(.OUT_W(16), .SHIFT(0), .ZERO_POINT(3), .NUM_CH(1)) u_sat (
      .clk(clk), .rst(rst), .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in),
      .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out), .last_out(b_last_out),
      .ch_clear(b_ch_clear), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data)
   );

   typedef struct {
      longint d;
      int     l;
      int     c;
   } exp_t;

   exp_t               exp_q [$];
   exp_t               e;
   int                 out_log [$];
   int                 last_log [$];
   int                 b_out_log [$];
   int                 b_last_log [$];
   int                 ed [$];
   int                 el [$];
   int                 scl_m [NCH];
   int                 ch_m;
   int                 ce;
   int                 cyc;
   bit                 lat_chk = 1'b1;
   bit                 hold_pend;
   logic signed [31:0] hold_d;
   logic               hold_l;
   int                 n_cmp = 0;
   int                 n_err = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic straight from the dequantization formula.
   function automatic longint ref_out(input longint x, input longint s, input int zp, input int sh, input int ow);
      longint p, hi, lo;
      p = (x - zp) * s;
      if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
      p  = p >>> sh;
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
      if (p > hi) p = hi;
      if (p < lo) p = lo;
      return p;
   endfunction

   // Scoreboard for the main instance, sampled mid-cycle; events take effect at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < NCH; i++) scl_m[i] = 256;
         ch_m      = 0;
         hold_pend = 1'b0;
      end else begin
         check("ready_in", ready_in, !(valid_out && !ready_out));
         if (hold_pend) begin
            check("hold_vld", valid_out, 1);
            check("hold_dat", data_out, hold_d);
            check("hold_last", last_out, hold_l);
         end
         hold_pend = valid_out && !ready_out;
         hold_d    = data_out;
         hold_l    = last_out;
         if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("data", data_out, e.d);
               check("last", last_out, e.l);
               if (lat_chk) check("latency", cyc - e.c, 2);
            end
            out_log.push_back(int'(data_out));
            last_log.push_back(int'(last_out));
         end
         if (valid_in && ready_in) begin
            ce  = ch_clear ? 0 : ch_m;
            e.d = ref_out(data_in, scl_m[ce], 0, 8, 32);
            e.l = (ce == NCH - 1) ? 1 : 0;
            e.c = cyc;
            exp_q.push_back(e);
            ch_m = (ce + 1) % NCH;
         end else if (ch_clear) begin
            ch_m = 0;
         end
         if (cfg_we && cfg_addr < NCH) scl_m[cfg_addr] = cfg_data;
         cyc++;
      end
   end

   // Output logger for the saturation instance.
   always @(negedge clk) begin
      if (!rst && b_valid_out && b_ready_out) begin
         b_out_log.push_back(int'(b_data_out));
         b_last_log.push_back(int'(b_last_out));
      end
   end

   task automatic step(input logic v, input logic signed [7:0] d, input logic clr,
                       input logic we, input logic [1:0] a, input logic signed [15:0] cd);
      valid_in = v; data_in = d; ch_clear = clr; cfg_we = we; cfg_addr = a; cfg_data = cd;
      @(posedge clk); #1;
      valid_in = 1'b0; ch_clear = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic bstep(input logic v, input logic signed [7:0] d, input logic we,
                        input logic [0:0] a, input logic signed [15:0] cd);
      b_valid_in = v; b_data_in = d; b_cfg_we = we; b_cfg_addr = a; b_cfg_data = cd;
      @(posedge clk); #1;
      b_valid_in = 1'b0; b_cfg_we = 1'b0;
   endtask

   task automatic drain();
      valid_in  = 1'b0;
      ready_out = 1'b1;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || valid_out); i++) begin
         @(posedge clk); #1;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic check_log(input string tag);
      check({tag, "_cnt"}, out_log.size(), ed.size());
      for (int i = 0; i < ed.size() && i < out_log.size(); i++) begin
         check($sformatf("%s_dat[%0d]", tag, i), out_log[i], ed[i]);
         check($sformatf("%s_last[%0d]", tag, i), last_log[i], el[i]);
      end
      out_log.delete();
      last_log.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 0);
      check("rst_last_out", last_out, 0);
      check("rst_ready_in", ready_in, 1);
      check("rst_b_valid_out", b_valid_out, 0);
      @(posedge clk); #1;

      // Identity with the default multiplier, back-to-back, fixed two-cycle latency.
      out_log.delete(); last_log.delete();
      step(1, 5, 0, 0, 0, 0);
      step(1, -7, 0, 0, 0, 0);
      step(1, 127, 0, 0, 0, 0);
      step(1, -128, 0, 0, 0, 0);
      drain();
      ed = '{5, -7, 127, -128}; el = '{0, 0, 0, 1};
      check_log("ident");

      // Rounding: half-LSB cases go toward +inf.
      for (int i = 0; i < NCH; i++) step(0, 0, 0, 1, 2'(i), 128);
      step(1, 3, 0, 0, 0, 0);
      step(1, -3, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      drain();
      ed = '{2, -1, 1}; el = '{0, 0, 0};
      check_log("round");

      // Per-channel scales, wrap, last flag and a clear coinciding with an accept.
      step(0, 0, 0, 1, 0, 256);
      step(0, 0, 0, 1, 1, 512);
      step(0, 0, 0, 1, 2, 768);
      step(0, 0, 0, 1, 3, -256);
      step(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      drain();
      ed = '{1, 2, 3, -1, 1, 1, 2}; el = '{0, 0, 0, 1, 0, 0, 0};
      check_log("chan");

      // Same-cycle write and accept on channel 0: old scale for this beat, new for the next.
      step(0, 0, 1, 0, 0, 0);
      step(1, 4, 0, 1, 0, 512);
      step(1, 4, 1, 0, 0, 0);
      drain();
      ed = '{4, 8}; el = '{0, 0};
      check_log("hazard");

      // Random traffic with random backpressure, config writes and clears.
      lat_chk = 1'b0;
      for (int i = 0; i < 400; i++) begin
         ready_out = ($urandom_range(0, 3) != 0);
         valid_in  = ($urandom_range(0, 2) != 0);
         data_in   = 8'($urandom);
         ch_clear  = ($urandom_range(0, 15) == 0);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_addr  = 2'($urandom);
         cfg_data  = 16'($urandom);
         @(posedge clk); #1;
      end
      ch_clear = 1'b0; cfg_we = 1'b0;
      drain();
      lat_chk = 1'b1;
      out_log.delete(); last_log.delete();

      // Reset with two beats in flight: both discarded, table back to the default multiplier.
      for (int i = 0; i < NCH; i++) step(0, 0, 0, 1, 2'(i), 512);
      step(0, 0, 1, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0);
      #1 rst = 1'b1;
      #1;
      check("midrst_valid_out", valid_out, 0);
      check("midrst_data_out", data_out, 0);
      @(posedge clk); #1 rst = 1'b0;
      step(1, 4, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0);
      drain();
      ed = '{4, 4}; el = '{0, 0};
      check_log("midrst");

      // Narrow output, SHIFT=0, zero point 3, single channel.
      bstep(0, 0, 1, 0, 32767);
      bstep(1, 127, 1, 0, -32768);
      bstep(1, 127, 0, 0, 0);
      bstep(1, -128, 0, 0, 0);
      bstep(1, 3, 1, 0, 5);
      bstep(1, -20, 0, 0, 0);
      bstep(0, 0, 1, 1, 1000);
      bstep(1, 13, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      ed = '{32767, -32768, 32767, 0, -115, 50};
      check("sat_cnt", b_out_log.size(), ed.size());
      for (int i = 0; i < ed.size() && i < b_out_log.size(); i++) begin
         check($sformatf("sat_dat[%0d]", i), b_out_log[i], ed[i]);
         check($sformatf("sat_last[%0d]", i), b_last_log[i], 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
